// File: rtl/ser_pkg.sv
// Shared types and helpers for the 8-bit serializer slice.
// Holds the FSM state encoding, the default word width and the parity helper.
package ser_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

    localparam int unsigned DW_DEFAULT = 8;

    // Even parity over a word zero-extended to 16 bits (legal DW never exceeds 16).
    function automatic logic even_parity(input logic [15:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/ser_bitcnt.sv
// Bit counter for the serializer: counts live bits within a frame.
// Saturates at DW-1 so it never wraps inside a frame; 'last' flags DW-1.
import ser_pkg::*;

module ser_bitcnt #(
    parameter int unsigned DW = DW_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  enable,
    output logic [$clog2(DW)-1:0] count,
    output logic                  last
);

    localparam int unsigned CW = $clog2(DW);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign count = count_q;
    assign last  = (count_q == CW'(DW - 1));

    // Next count: clear wins, otherwise step while below the last bit.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !last) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/serializer_8bit.sv
// Parallel-to-serial converter, LSB first, with downstream shift-enable stall.
// Optional even-parity bit after the data bits when SERIALIZER_PARITY_EN is defined.
import ser_pkg::*;

module serializer_8bit #(
    parameter int unsigned DW = DW_DEFAULT
) (
    input  logic          Clk,
    input  logic          RSn,
    input  logic [DW-1:0] PD,
    input  logic          PValid,
    output logic          PReady,
    input  logic          SEn,
    output logic          SOD,
    output logic          SValid,
    output logic          FrameDone
);

    localparam int unsigned CW = $clog2(DW);

    state_t        state_q;
    state_t        state_d;
    logic [DW-1:0] buf_q;
    logic [DW-1:0] buf_d;
    logic          cnt_clear;
    logic          cnt_en;
    logic          cnt_last;
    logic [CW-1:0] cnt;
`ifdef SERIALIZER_PARITY_EN
    logic          par_q;
    logic          par_d;
`endif

    ser_bitcnt #(
        .DW(DW)
    ) u_bitcnt (
        .clk    (Clk),
        .rst_n  (RSn),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .count  (cnt),
        .last   (cnt_last)
    );

    // FSM next state, buffer update and all outputs; everything holds while SEn is low.
    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        PReady    = 1'b0;
        SOD       = 1'b0;
        SValid    = 1'b0;
        FrameDone = 1'b0;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
`ifdef SERIALIZER_PARITY_EN
        par_d     = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                PReady = 1'b1;
                if (PValid) begin
                    buf_d     = PD;
                    cnt_clear = 1'b1;
                    state_d   = SHIFT;
`ifdef SERIALIZER_PARITY_EN
                    par_d     = even_parity(16'(PD));
`endif
                end
            end
            SHIFT: begin
                SOD    = buf_q[0];
                SValid = SEn;
                if (SEn) begin
                    buf_d  = buf_q >> 1;
                    cnt_en = 1'b1;
                    if (cnt_last) begin
`ifdef SERIALIZER_PARITY_EN
                        state_d = PAR;
`else
                        state_d   = IDLE;
                        FrameDone = 1'b1;
`endif
                    end
                end
            end
`ifdef SERIALIZER_PARITY_EN
            PAR: begin
                SOD    = par_q;
                SValid = SEn;
                if (SEn) begin
                    FrameDone = 1'b1;
                    state_d   = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and data registers with asynchronous active-low reset.
    always_ff @(posedge Clk or negedge RSn) begin
        if (!RSn) begin
            state_q <= IDLE;
            buf_q   <= '0;
`ifdef SERIALIZER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
`ifdef SERIALIZER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    counter_in_range: assert property (@(posedge Clk) disable iff (!RSn) cnt <= CW'(DW - 1));

endmodule

// File: tb/tb_serializer_8bit.sv
// Directed self-checking bench for serializer_8bit (DW=8).
// Inputs change just after the falling edge; outputs are sampled 1ns later.
module tb_serializer_8bit;

    localparam int unsigned DW = 8;
`ifdef SERIALIZER_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic       Clk = 1'b0;
    logic       RSn = 1'b1;
    logic [7:0] PD = '0;
    logic       PValid = 1'b0;
    logic       SEn = 1'b0;
    logic       PReady;
    logic       SOD;
    logic       SValid;
    logic       FrameDone;

    int n_cmp = 0;
    int n_err = 0;

    logic bits [64];
    int   nbits, fd_cnt, fd_first, fd_last, fd_bit, acc_cyc, cyc;
    logic s_ready, s_sod, s_sval, s_fd;

    logic seq_a5 [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    always #5 Clk = ~Clk;

    serializer_8bit #(
        .DW(DW)
    ) dut (
        .Clk       (Clk),
        .RSn       (RSn),
        .PD        (PD),
        .PValid    (PValid),
        .PReady    (PReady),
        .SEn       (SEn),
        .SOD       (SOD),
        .SValid    (SValid),
        .FrameDone (FrameDone)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Word seen by the downstream register after 8 live bits starting at 'off'.
    function automatic logic [7:0] word_at(input int off);
        logic [7:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) w[i] = bits[off + i];
        return w;
    endfunction

    task automatic clr_rec();
        nbits = 0; fd_cnt = 0; fd_first = -1; fd_last = -1; fd_bit = -1;
        acc_cyc = -1; cyc = 0;
        for (int i = 0; i < 64; i++) bits[i] = 1'b0;
    endtask

    task automatic cycle(input logic pv, input logic [7:0] pd, input logic sen);
        @(negedge Clk);
        PValid = pv; PD = pd; SEn = sen;
        #1;
        s_ready = PReady; s_sod = SOD; s_sval = SValid; s_fd = FrameDone;
        if (s_sval && nbits < 64) begin
            bits[nbits] = s_sod;
            nbits++;
        end
        if (s_fd) begin
            fd_cnt++;
            if (fd_first < 0) fd_first = cyc;
            fd_last = cyc;
            fd_bit  = nbits;
        end
        if (pv && s_ready) acc_cyc = cyc;
        cyc++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, observed without any clock edge
        #2 RSn = 1'b0;
        #1;
        chk("rst_ready", 32'(PReady), 1);
        chk("rst_sod", 32'(SOD), 0);
        chk("rst_svalid", 32'(SValid), 0);
        chk("rst_fdone", 32'(FrameDone), 0);
        repeat (2) @(negedge Clk);
        RSn = 1'b1;

        // A5 with SEn held high
        clr_rec();
        cycle(1'b1, 8'hA5, 1'b1);
        chk("a5_accept_ready", 32'(s_ready), 1);
        repeat (FL) cycle(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 8; i++) chk($sformatf("a5_bit%0d", i), 32'(bits[i]), 32'(seq_a5[i]));
        chk("a5_nbits", nbits, FL);
        chk("a5_fd_count", fd_cnt, 1);
        chk("a5_fd_cycle", fd_last, FL);
        chk("a5_fd_bit", fd_bit, FL);
        chk("a5_q", 32'(word_at(0)), 'hA5);
        cycle(1'b0, 8'h00, 1'b1);
        chk("idle_ready", 32'(s_ready), 1);
        chk("idle_svalid", 32'(s_sval), 0);
        chk("idle_sod", 32'(s_sod), 0);
        chk("idle_fdone", 32'(s_fd), 0);

        // 3C with a 3-cycle stall after bit 2 (bit 2 of 3C is 1)
        clr_rec();
        cycle(1'b1, 8'h3C, 1'b1);
        repeat (3) cycle(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'h00, 1'b0);
            chk($sformatf("stall%0d_svalid", i), 32'(s_sval), 0);
            chk($sformatf("stall%0d_sod", i), 32'(s_sod), 1);
        end
        repeat (FL - 3) cycle(1'b0, 8'h00, 1'b1);
        chk("3c_fd_cycle", fd_last, FL + 3);
        chk("3c_fd_count", fd_cnt, 1);
        chk("3c_nbits", nbits, FL);
        chk("3c_q", 32'(word_at(0)), 'h3C);
        cycle(1'b0, 8'h00, 1'b1);

        // PValid held with PD changed to FF mid-frame
        clr_rec();
        cycle(1'b1, 8'hA5, 1'b1);
        for (int i = 0; i < FL; i++) begin
            cycle(1'b1, 8'hFF, 1'b1);
            chk($sformatf("busy%0d_ready", i), 32'(s_ready), 0);
        end
        chk("hold_q_a5", 32'(word_at(0)), 'hA5);
        chk("hold_fd_count", fd_cnt, 1);
        cycle(1'b1, 8'hFF, 1'b1);
        chk("ff_accept_ready", 32'(s_ready), 1);
        chk("ff_accept_cycle", acc_cyc, FL + 1);
        repeat (FL) cycle(1'b0, 8'h00, 1'b1);
        chk("ff_q", 32'(word_at(FL)), 'hFF);
        chk("ff_fd_count", fd_cnt, 2);

        // Reset during bit 4 of F0, then 81
        clr_rec();
        cycle(1'b1, 8'hF0, 1'b1);
        repeat (4) cycle(1'b0, 8'h00, 1'b1);
        @(negedge Clk);
        PValid = 1'b0; SEn = 1'b1;
        #1;
        chk("f0_bit4_live", 32'({SValid, SOD}), 'b11);
        #1 RSn = 1'b0;
        #1;
        chk("arst_svalid", 32'(SValid), 0);
        chk("arst_sod", 32'(SOD), 0);
        chk("arst_ready", 32'(PReady), 1);
        chk("arst_fdone", 32'(FrameDone), 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            #1 chk($sformatf("inrst%0d_fdone", i), 32'(FrameDone), 0);
        end
        RSn = 1'b1;
        chk("f0_fd_count", fd_cnt, 0);
        clr_rec();
        cycle(1'b1, 8'h81, 1'b1);
        chk("81_accept_ready", 32'(s_ready), 1);
        repeat (FL) cycle(1'b0, 8'h00, 1'b1);
        chk("81_q", 32'(word_at(0)), 'h81);
        chk("81_fd_cycle", fd_last, FL);
        chk("81_fd_count", fd_cnt, 1);

        // Back-to-back 01 then 80
        clr_rec();
        cycle(1'b1, 8'h01, 1'b1);
        repeat (FL + 1) cycle(1'b1, 8'h80, 1'b1);
        repeat (FL) cycle(1'b0, 8'h00, 1'b1);
        chk("b2b_fd_first", fd_first, FL);
        chk("b2b_accept2", acc_cyc, FL + 1);
        chk("b2b_fd_last", fd_last, 2 * FL + 1);
        chk("b2b_nbits", nbits, 2 * FL);
        chk("b2b_q01", 32'(word_at(0)), 'h01);
        chk("b2b_q80", 32'(word_at(FL)), 'h80);
        chk("b2b_fd_count", fd_cnt, 2);

`ifdef SERIALIZER_PARITY_EN
        // Parity: 07 has odd weight -> parity bit 1; A5 even weight -> 0
        clr_rec();
        cycle(1'b1, 8'h07, 1'b1);
        repeat (FL) cycle(1'b0, 8'h00, 1'b1);
        chk("p07_nbits", nbits, 9);
        chk("p07_parity", 32'(bits[8]), 1);
        chk("p07_fd_bit", fd_bit, 9);
        chk("p07_q", 32'(word_at(0)), 'h07);
        clr_rec();
        cycle(1'b1, 8'hA5, 1'b1);
        repeat (FL) cycle(1'b0, 8'h00, 1'b1);
        chk("pa5_parity", 32'(bits[8]), 0);
        chk("pa5_fd_bit", fd_bit, 9);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serializer_8bit.md
SERIALIZER_8BIT -- requirements
Module: serializer_8bit

Interface
REQ-001 SHALL have parameter DW, default 8, meaning parallel word width in bits (legal range 2..16).
REQ-002 SHALL have port Clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RSn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port PD  input  DW  parallel word to serialize.
REQ-005 SHALL have port PValid  input  1  PD holds a valid word.
REQ-006 SHALL have port PReady  output  1  block can accept a word this cycle.
REQ-007 SHALL have port SEn  input  1  downstream shift enable; low stalls the bit stream.
REQ-008 SHALL have port SOD  output  1  serial data, wired to the downstream shift register's SID.
REQ-009 SHALL have port SValid  output  1  SOD carries a live bit this cycle; drives the downstream register's clock enable.
REQ-010 SHALL have port FrameDone  output  1  one-cycle pulse on the last bit of a frame.

Function
REQ-011 SHALL implement states IDLE, SHIFT and (with the parity feature) PAR.
REQ-012 SHALL transfer a word on a rising edge where PValid=1 and PReady=1, capturing PD into an internal buffer and entering SHIFT.
REQ-013 SHALL drive PReady=1 only in IDLE; PValid and PD SHALL be ignored in every other state.
REQ-014 SHALL emit bits LSB first, so that after DW shifts the downstream register holds Q==PD.
REQ-015 In SHIFT, SHALL drive SOD=buf[0] and SValid=SEn; on an edge with SEn=1 the buffer SHALL shift right and the bit counter SHALL increment.
REQ-016 With SEn=0, SHALL hold SOD, the buffer and the counter unchanged and drive SValid=0.
REQ-017 When the counter reaches DW-1 with SEn=1, SHALL go to PAR if enabled, otherwise to IDLE; FrameDone SHALL be 1 during that final live-bit cycle only.
REQ-018 Latency with SEn held at 1: accept at edge N, bit 0 valid after edge N, last bit valid after edge N+DW-1, PReady=1 again after edge N+DW (N+DW+1 with parity).
REQ-019 In IDLE, SHALL drive SOD=0, SValid=0 and FrameDone=0.
REQ-020 Counter width SHALL be $clog2(DW) bits; it SHALL never wrap within a frame and SHALL be cleared on entry to SHIFT.

Reset
REQ-021 RSn=0 SHALL immediately force state IDLE, buffer 0, counter 0, PReady=1, SOD=0, SValid=0, FrameDone=0, regardless of Clk.
REQ-022 Reset asserted mid-frame SHALL abort the frame with no FrameDone pulse; the first edge after RSn rises SHALL behave as in IDLE.

Configuration
REQ-023 Macro SERIALIZER_PARITY_EN SHALL, when defined, enable state PAR: one extra bit SOD = XOR of the captured word (even parity), SValid=SEn, stalled by SEn like data bits; FrameDone SHALL then pulse on the parity bit instead of data bit DW-1.
REQ-024 Without SERIALIZER_PARITY_EN, SHALL contain no PAR state or parity logic, and frames SHALL be exactly DW bits.

Structure
REQ-025 SHALL place the state enum (IDLE, SHIFT, PAR), the DW default constant and the parity function in shared package ser_pkg.
REQ-026 SHALL implement the bit counter as sub-module ser_bitcnt (inputs clear and enable; outputs count and a last flag).

Verification
REQ-027 Bench SHALL cover: PD=8'hA5, PValid pulse, SEn=1 -> SOD sequence 1,0,1,0,0,1,0,1; FrameDone on bit 8; downstream Q=8'hA5.
REQ-028 Bench SHALL cover: PD=8'h3C with SEn low for 3 cycles after bit 2 -> SValid=0 and SOD held during the stall; frame completes 3 cycles late; Q=8'h3C.
REQ-029 Bench SHALL cover: PValid held high with PD changed to 8'hFF mid-frame -> PReady=0 and the frame still emits 8'hA5; 8'hFF accepted on the first IDLE cycle.
REQ-030 Bench SHALL cover: RSn pulled low after bit 4 of 8'hF0 -> SValid=0, SOD=0 and PReady=1 asynchronously, no FrameDone; a following 8'h81 serializes correctly.
REQ-031 Bench SHALL cover, with SERIALIZER_PARITY_EN: PD=8'h07 -> 9 live bits, parity bit 1, FrameDone on bit 9; PD=8'hA5 -> parity bit 0.
REQ-032 Bench SHALL cover: two back-to-back words 8'h01 and 8'h80 -> 8'h80 accepted one cycle after FrameDone for 8'h01 (no parity); no gap or overlap beyond that.
